// File: rtl/overvoltage_pkg.sv
`default_nettype none
// ============================================================================
// overvoltage_pkg - FSM state type, default parameters and tap decode helpers.
// Revision 1.0
// ============================================================================
package overvoltage_pkg;

  localparam int SEL_W_DEF     = 4;
  localparam int BBM_CYC_DEF   = 2;
  localparam int BLANK_CYC_DEF = 8;
  localparam int DEB_CYC_DEF   = 4;
  localparam int SEL_W_MAX     = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    BBM    = 2'd1,
    SETTLE = 2'd2,
    ACTIVE = 2'd3
  } ov_state_t;

  // Decodes at the widest supported code width; callers truncate to their own width.
  function automatic logic [2**SEL_W_MAX-1:0] onehot_decode(input logic [SEL_W_MAX-1:0] code);
    logic [2**SEL_W_MAX-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

  function automatic int cnt_width(input int max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov_debounce.sv
`default_nettype none
// ============================================================================
// ov_debounce - 2-flop synchroniser plus agreement counter for the comparator.
// Revision 1.0
// ============================================================================
module ov_debounce
  import overvoltage_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int                DEB_W    = cnt_width(DEB_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] dcnt;
  logic             disagree;
  logic             at_last;

  assign disagree = (sync2 != dout);
  assign at_last  = (dcnt >= DEB_LAST);
  // Flagged one cycle early so the parent can register its sticky flag on the same edge.
  assign rise     = en && !clr && disagree && at_last && !dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt  <= '0;
      dout  <= 1'b0;
    end else if (clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt  <= '0;
      dout  <= 1'b0;
    end else if (en) begin
      sync1 <= din;
      sync2 <= sync1;
      if (!disagree) begin
        dcnt <= '0;
      end else if (at_last) begin
        dout <= ~dout;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DEB_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/overvoltage_trip_ctrl.sv
`default_nettype none
// ============================================================================
// overvoltage_trip_ctrl - trip code to ladder tap decode with break-before-make,
// comparator blanking, debounce and sticky overvoltage flag.  Revision 1.0
// ============================================================================
module overvoltage_trip_ctrl
  import overvoltage_pkg::*;
#(
  parameter int SEL_W     = SEL_W_DEF,
  parameter int BBM_CYC   = BBM_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int DEB_CYC   = DEB_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [SEL_W-1:0]    otrip,
  input  logic                vin_cmp,
  input  logic                flag_clr,
  output logic [2**SEL_W-1:0] otrip_decoded,
  output logic                ovout,
  output logic                ov_flag,
  output logic                busy
);

  localparam int               DEC_W      = 2**SEL_W;
  localparam int               CNT_MAX    = ((BBM_CYC > BLANK_CYC) ? BBM_CYC : BLANK_CYC) - 1;
  localparam int               CNT_W      = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] BBM_LAST   = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  ov_state_t        state;
  logic [SEL_W-1:0] code_q;
  logic [CNT_W-1:0] cnt;
  logic             code_chg;
  logic             run;
  logic             rise;

  assign code_chg = (otrip != code_q);
  // Debounce only runs while ACTIVE is held; any exit clears ovout on the same edge.
  assign run      = (state == ACTIVE) && ena && !code_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= OFF;
      code_q        <= '0;
      cnt           <= '0;
      otrip_decoded <= '0;
      busy          <= 1'b0;
      ov_flag       <= 1'b0;
    end else begin
      if (rise) begin
        ov_flag <= 1'b1;
      end else if (flag_clr) begin
        ov_flag <= 1'b0;
      end

      if (!ena) begin
        state         <= OFF;
        cnt           <= '0;
        otrip_decoded <= '0;
        busy          <= 1'b0;
      end else begin
        case (state)
          OFF: begin
            state         <= BBM;
            code_q        <= otrip;
            cnt           <= '0;
            otrip_decoded <= '0;
            busy          <= 1'b1;
          end
          BBM: begin
            if (code_chg) begin
              code_q <= otrip;
              cnt    <= '0;
            end else if (cnt >= BBM_LAST) begin
              state         <= SETTLE;
              cnt           <= '0;
              otrip_decoded <= DEC_W'(onehot_decode(SEL_W_MAX'(code_q)));
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SETTLE, ACTIVE: begin
            if (code_chg) begin
              state         <= BBM;
              code_q        <= otrip;
              cnt           <= '0;
              otrip_decoded <= '0;
              busy          <= 1'b1;
            end else if (state == SETTLE) begin
              if (cnt >= BLANK_LAST) begin
                state <= ACTIVE;
                cnt   <= '0;
                busy  <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= OFF;
          end
        endcase
      end
    end
  end

  ov_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (!run),
    .din  (vin_cmp),
    .dout (ovout),
    .rise (rise)
  );

endmodule
`default_nettype wire

// File: tb/tb_overvoltage_trip_ctrl.sv
`default_nettype none
// ============================================================================
// tb_overvoltage_trip_ctrl - timed-expectation scoreboard for the trip controller.
// Revision 1.0
// ============================================================================
module tb_overvoltage_trip_ctrl;

  localparam int K_DEC  = 0;
  localparam int K_OV   = 1;
  localparam int K_FLAG = 2;
  localparam int K_BUSY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  otrip;
  logic        vin_cmp;
  logic        flag_clr;
  logic [15:0] otrip_decoded;
  logic        ovout;
  logic        ov_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  overvoltage_trip_ctrl #(
    .SEL_W     (4),
    .BBM_CYC   (2),
    .BLANK_CYC (8),
    .DEB_CYC   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .otrip         (otrip),
    .vin_cmp       (vin_cmp),
    .flag_clr      (flag_clr),
    .otrip_decoded (otrip_decoded),
    .ovout         (ovout),
    .ov_flag       (ov_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_DEC:   return 32'(otrip_decoded);
      K_OV:    return 32'(ovout);
      K_FLAG:  return 32'(ov_flag);
      default: return 32'(busy);
    endcase
  endfunction

  task automatic exp_rng(input string tag, input int kind, input logic [15:0] val,
                         input int from, input int to);
    for (int c = from; c <= to; c++) sbq.push_back('{c, kind, val, tag});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard drain: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    if (!rst) check("onehot", 32'($countones(otrip_decoded) <= 1), 32'd1);
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        check(sbq[i].tag, observe(sbq[i].kind), 32'(sbq[i].val));
        sbq.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst = 1'b1; ena = 1'b0; otrip = 4'h0; vin_cmp = 1'b0; flag_clr = 1'b0;
    tick(3);
    check("rst_dec",  32'(otrip_decoded), 32'd0);
    check("rst_ov",   32'(ovout),         32'd0);
    check("rst_flag", 32'(ov_flag),       32'd0);
    check("rst_busy", 32'(busy),          32'd0);
    rst = 1'b0;
    tick(2);

    // Enable with code F: two open cycles, then tap 15; ten busy cycles.
    s = cyc; ena = 1'b1; otrip = 4'hF;
    exp_rng("en_open",  K_DEC,  16'h0000, s + 1,  s + 2);
    exp_rng("en_tap",   K_DEC,  16'h8000, s + 3,  s + 12);
    exp_rng("en_busy",  K_BUSY, 16'd1,    s + 1,  s + 10);
    exp_rng("en_idle",  K_BUSY, 16'd0,    s + 11, s + 12);
    exp_rng("en_ov",    K_OV,   16'd0,    s + 1,  s + 12);
    tick(12);

    // Code change in ACTIVE: F -> 3.
    s = cyc; otrip = 4'h3;
    exp_rng("chg_open", K_DEC,  16'h0000, s + 1,  s + 2);
    exp_rng("chg_tap",  K_DEC,  16'h0008, s + 3,  s + 12);
    exp_rng("chg_busy", K_BUSY, 16'd1,    s + 1,  s + 10);
    exp_rng("chg_idle", K_BUSY, 16'd0,    s + 11, s + 12);
    tick(12);

    // Second change during BBM restarts the break-before-make count.
    s = cyc; otrip = 4'h5;
    exp_rng("rbbm_open", K_DEC,  16'h0000, s + 1,  s + 3);
    exp_rng("rbbm_tap",  K_DEC,  16'h0200, s + 4,  s + 13);
    exp_rng("rbbm_busy", K_BUSY, 16'd1,    s + 1,  s + 11);
    exp_rng("rbbm_idle", K_BUSY, 16'd0,    s + 12, s + 13);
    tick(1);
    otrip = 4'h9;
    tick(12);

    // Disable, then re-enable with comparator already high: blanking check.
    s = cyc; ena = 1'b0;
    exp_rng("dis_dec",  K_DEC,  16'h0000, s + 1, s + 2);
    exp_rng("dis_busy", K_BUSY, 16'd0,    s + 1, s + 2);
    tick(2);
    s = cyc; ena = 1'b1; otrip = 4'hF; vin_cmp = 1'b1;
    exp_rng("blank_ov0",   K_OV,   16'd0, s + 1,  s + 16);
    exp_rng("blank_ov1",   K_OV,   16'd1, s + 17, s + 20);
    exp_rng("blank_flag0", K_FLAG, 16'd0, s + 1,  s + 16);
    exp_rng("prio_flag",   K_FLAG, 16'd1, s + 17, s + 18);
    exp_rng("clr_flag",    K_FLAG, 16'd0, s + 19, s + 20);
    tick(16);
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    tick(1);
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    tick(1);

    // Comparator falls: ovout clears after sync plus four agreeing samples.
    s = cyc; vin_cmp = 1'b0;
    exp_rng("fall_ov1",  K_OV,   16'd1, s + 1, s + 5);
    exp_rng("fall_ov0",  K_OV,   16'd0, s + 6, s + 7);
    exp_rng("fall_flag", K_FLAG, 16'd0, s + 6, s + 6);
    tick(7);

    // Three-cycle glitch is rejected.
    s = cyc; vin_cmp = 1'b1;
    exp_rng("glitch3_ov", K_OV, 16'd0, s + 1, s + 10);
    tick(3);
    vin_cmp = 1'b0;
    tick(7);

    // Four-cycle pulse is accepted, then released.
    s = cyc; vin_cmp = 1'b1;
    exp_rng("pulse4_ov0",  K_OV,   16'd0, s + 1,  s + 5);
    exp_rng("pulse4_ov1",  K_OV,   16'd1, s + 6,  s + 9);
    exp_rng("pulse4_rel",  K_OV,   16'd0, s + 10, s + 11);
    exp_rng("pulse4_f0",   K_FLAG, 16'd0, s + 1,  s + 5);
    exp_rng("pulse4_f1",   K_FLAG, 16'd1, s + 6,  s + 11);
    tick(4);
    vin_cmp = 1'b0;
    tick(7);

    // Asynchronous reset in the middle of SETTLE with code 5.
    s = cyc; otrip = 4'h5;
    exp_rng("pre_open", K_DEC,  16'h0000, s + 1, s + 2);
    exp_rng("pre_tap",  K_DEC,  16'h0020, s + 3, s + 4);
    exp_rng("pre_busy", K_BUSY, 16'd1,    s + 1, s + 4);
    tick(5);
    #1 rst = 1'b1;
    #1;
    check("arst_dec",  32'(otrip_decoded), 32'd0);
    check("arst_ov",   32'(ovout),         32'd0);
    check("arst_flag", 32'(ov_flag),       32'd0);
    check("arst_busy", 32'(busy),          32'd0);
    tick(2);
    s = cyc; rst = 1'b0;
    exp_rng("rel_open", K_DEC,  16'h0000, s + 1,  s + 2);
    exp_rng("rel_tap",  K_DEC,  16'h0020, s + 3,  s + 12);
    exp_rng("rel_busy", K_BUSY, 16'd1,    s + 1,  s + 10);
    exp_rng("rel_idle", K_BUSY, 16'd0,    s + 11, s + 12);
    exp_rng("rel_flag", K_FLAG, 16'd0,    s + 1,  s + 12);
    tick(13);

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
